// File: rtl/scope_trigger_capture_if.sv
// Bundles the sample stream, capture controls and readout port of the scope trigger/capture block.
// The master side is the ADC front end plus display logic; the slave side is the capture engine.
interface scope_trigger_capture_if #(
  parameter int DW = 12,
  parameter int AW = 9
);
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          arm;
  logic [DW-1:0] trig_level;
  logic          trig_slope;
  logic [3:0]    dec_sel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          trig_auto;

  modport master (
    output sample_in, sample_valid, arm, trig_level, trig_slope, dec_sel, rd_addr,
    input  rd_data, busy, done, trig_auto
  );

  modport slave (
    input  sample_in, sample_valid, arm, trig_level, trig_slope, dec_sel, rd_addr,
    output rd_data, busy, done, trig_auto
  );
endinterface

// File: rtl/scope_trigger_capture.sv
// Decimates an ADC sample stream, waits for an edge (or auto timeout) and freezes a
// pre/post-trigger window in a circular RAM that is read back relative to the trigger.
module scope_trigger_capture #(
  parameter int DW       = 12,
  parameter int AW       = 9,
  parameter int PRE_TRIG = 128,
  parameter int AUTO_TO  = 4096
) (
  input logic                    CLOCK_50,
  input logic                    reset_n,
  scope_trigger_capture_if.slave bus
);

  localparam int DEPTH  = 2 ** AW;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // With no pre-trigger window the capture can start hunting for an edge straight away.
  localparam logic [2:0]    START_STATE = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
  localparam logic [AW:0]   PRE_LAST    = (AW+1)'(PRE_TRIG);
  localparam logic [AW:0]   POST_LAST   = (AW+1)'(POST_N);
  localparam logic [31:0]   AUTO_LAST   = 32'(AUTO_TO - 1);
  localparam logic [AW-1:0] PRE_OFS     = AW'(PRE_TRIG);

  logic [2:0]    state_reg, state_next;
  logic [3:0]    dec_sel_reg, dec_sel_next;
  logic [14:0]   dec_cnt_reg, dec_cnt_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] trig_ptr_reg, trig_ptr_next;
  logic [AW-1:0] pre_cnt_reg, pre_cnt_next;
  logic [AW-1:0] post_cnt_reg, post_cnt_next;
  logic [31:0]   auto_cnt_reg, auto_cnt_next;
  logic [DW-1:0] prev_sample_reg, prev_sample_next;
  logic          prev_valid_reg, prev_valid_next;
  logic [DW-1:0] trig_level_reg;
  logic          trig_slope_reg;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          trig_auto_reg, trig_auto_next;
  logic [DW-1:0] rd_data_reg;

  logic [2:0]    st_eff;
  logic [AW-1:0] pre_eff;
  logic [31:0]   auto_eff;
  logic          pv_eff;
  logic          accept;
  logic          write_en;
  logic          rise_hit, fall_hit, edge_hit;
  logic [AW:0]   pre_inc, post_inc;
  logic [15:0]   dec_mask_wide;
  logic [14:0]   dec_base;
  logic [AW-1:0] rd_phys;

  logic [DW-1:0] mem [DEPTH];

  // Decimation: arm clears the counter and loads the new ratio, so an arm-cycle strobe is kept.
  always_comb begin
    dec_mask_wide = (16'd1 << (bus.arm ? bus.dec_sel : dec_sel_reg)) - 16'd1;
    dec_base      = bus.arm ? 15'd0 : dec_cnt_reg;
    accept        = bus.sample_valid && (dec_base == 15'd0);
    dec_cnt_next  = dec_base;
    if (bus.sample_valid) begin
      dec_cnt_next = (dec_base + 15'd1) & dec_mask_wide[14:0];
    end
  end

  assign rise_hit = (prev_sample_reg < trig_level_reg) && (bus.sample_in >= trig_level_reg);
  assign fall_hit = (prev_sample_reg > trig_level_reg) && (bus.sample_in <= trig_level_reg);

  always_comb begin
    st_eff         = state_reg;
    pre_eff        = pre_cnt_reg;
    auto_eff       = auto_cnt_reg;
    pv_eff         = prev_valid_reg;
    dec_sel_next   = dec_sel_reg;
    trig_auto_next = trig_auto_reg;
    // arm overrides whatever the FSM was doing; the same cycle's sample then belongs to the new capture.
    if (bus.arm) begin
      st_eff         = START_STATE;
      pre_eff        = '0;
      auto_eff       = '0;
      pv_eff         = 1'b0;
      dec_sel_next   = bus.dec_sel;
      trig_auto_next = 1'b0;
    end

    state_next       = st_eff;
    pre_cnt_next     = pre_eff;
    auto_cnt_next    = auto_eff;
    prev_valid_next  = pv_eff;
    post_cnt_next    = post_cnt_reg;
    wr_ptr_next      = wr_ptr_reg;
    trig_ptr_next    = trig_ptr_reg;
    prev_sample_next = prev_sample_reg;

    write_en = accept && ((st_eff == S_FILL) || (st_eff == S_ARMED) || (st_eff == S_POST));
    edge_hit = pv_eff && (trig_slope_reg ? fall_hit : rise_hit);
    pre_inc  = {1'b0, pre_eff} + {{AW{1'b0}}, 1'b1};
    post_inc = {1'b0, post_cnt_reg} + {{AW{1'b0}}, 1'b1};

    if (write_en) begin
      wr_ptr_next      = wr_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
      prev_sample_next = bus.sample_in;
      prev_valid_next  = 1'b1;
      case (st_eff)
        S_FILL: begin
          pre_cnt_next = pre_inc[AW-1:0];
          if (pre_inc == PRE_LAST) begin
            state_next    = S_ARMED;
            auto_cnt_next = '0;
          end
        end
        S_ARMED: begin
          // A real edge wins over the timeout when both land on the same sample.
          if (edge_hit || ((AUTO_TO != 0) && (auto_eff == AUTO_LAST))) begin
            trig_ptr_next  = wr_ptr_reg;
            post_cnt_next  = '0;
            trig_auto_next = !edge_hit;
            state_next     = (POST_N == 0) ? S_DONE : S_POST;
          end else begin
            auto_cnt_next = auto_eff + 32'd1;
          end
        end
        S_POST: begin
          post_cnt_next = post_inc[AW-1:0];
          if (post_inc == POST_LAST) begin
            state_next = S_DONE;
          end
        end
        default: begin
          state_next = st_eff;
        end
      endcase
    end

    busy_next = (state_next == S_FILL) || (state_next == S_ARMED) || (state_next == S_POST);
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      dec_sel_reg     <= '0;
      dec_cnt_reg     <= '0;
      wr_ptr_reg      <= '0;
      trig_ptr_reg    <= '0;
      pre_cnt_reg     <= '0;
      post_cnt_reg    <= '0;
      auto_cnt_reg    <= '0;
      prev_sample_reg <= '0;
      prev_valid_reg  <= 1'b0;
      trig_level_reg  <= '0;
      trig_slope_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      trig_auto_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dec_sel_reg     <= dec_sel_next;
      dec_cnt_reg     <= dec_cnt_next;
      wr_ptr_reg      <= wr_ptr_next;
      trig_ptr_reg    <= trig_ptr_next;
      pre_cnt_reg     <= pre_cnt_next;
      post_cnt_reg    <= post_cnt_next;
      auto_cnt_reg    <= auto_cnt_next;
      prev_sample_reg <= prev_sample_next;
      prev_valid_reg  <= prev_valid_next;
      trig_level_reg  <= bus.trig_level;
      trig_slope_reg  <= bus.trig_slope;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      trig_auto_reg   <= trig_auto_next;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (write_en) begin
      mem[wr_ptr_reg] <= bus.sample_in;
    end
  end

  // Logical index 0 is the oldest pre-trigger sample; AW-bit math gives the circular wrap.
  assign rd_phys = trig_ptr_reg - PRE_OFS + bus.rd_addr;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_phys];
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.trig_auto = trig_auto_reg;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Scoreboard bench for scope_trigger_capture: a window model built from the sample stream
// predicts status and readout, and a negedge monitor pops and compares DUT responses.
module tb_scope_trigger_capture;
  localparam int DW      = 12;
  localparam int AW      = 9;
  localparam int DEPTH   = 512;
  localparam int PRE     = 128;
  localparam int AUTO_TO = 4096;
  localparam int POST_N  = DEPTH - PRE - 1;
  localparam int MAXN    = 16384;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  scope_trigger_capture_if #(.DW(DW), .AW(AW)) bus ();

  scope_trigger_capture #(.DW(DW), .AW(AW), .PRE_TRIG(PRE), .AUTO_TO(AUTO_TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [2:0] st_q[$];
  logic       rd_stb   = 1'b0;
  logic       rd_stb_d = 1'b0;
  logic       st_stb   = 1'b0;
  int         errors   = 0;
  int         checks   = 0;

  logic [DW-1:0] stream [MAXN];
  logic [DW-1:0] win [DEPTH];
  int            need;
  bit            exp_auto;

  // ---------------- monitor ----------------
  always @(posedge CLOCK_50) rd_stb_d <= rd_stb;

  always @(negedge CLOCK_50) begin
    rd_exp_t    re;
    logic [2:0] se;
    if (rd_stb_d) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %0d with no expected entry queued", bus.rd_data);
      end else begin
        re = rd_q.pop_front();
        if (bus.rd_data !== re.data) begin
          errors++;
          $display("FAIL rd_data addr=%0d got=%0d exp=%0d", re.addr, bus.rd_data, re.data);
        end else
          $display("read   addr=%0d data=%0d ok", re.addr, bus.rd_data);
      end
    end
    if (st_stb) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL status: no expected entry queued");
      end else begin
        se = st_q.pop_front();
        if ({bus.busy, bus.done, bus.trig_auto} !== se) begin
          errors++;
          $display("FAIL status busy/done/auto got=%b%b%b exp=%b", bus.busy, bus.done, bus.trig_auto, se);
        end else
          $display("status busy=%b done=%b auto=%b ok", bus.busy, bus.done, bus.trig_auto);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [DW-1:0] s);
    if ($urandom_range(0, 3) == 0) tick();
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic check_status(input logic b, input logic d, input logic a);
    st_q.push_back({b, d, a});
    st_stb = 1'b1;
    tick();
    st_stb = 1'b0;
  endtask

  task automatic check_read(input int a, input logic [DW-1:0] e);
    rd_exp_t x;
    x.addr = AW'(a);
    x.data = e;
    rd_q.push_back(x);
    bus.rd_addr = AW'(a);
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
  endtask

  // Reference model: kept samples are every 2**d-th valid strobe since arm; the trigger is the first
  // kept sample at or after PRE whose predecessor/current pair crosses the level, else the timeout one.
  task automatic model(input int d, input int lvl, input bit slope);
    int  t;
    int  p;
    int  c;
    bit  hit;
    t = -1;
    for (int j = PRE; j < PRE + AUTO_TO && t < 0; j++) begin
      p   = int'(stream[(j-1) << d]);
      c   = int'(stream[j << d]);
      hit = slope ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
      if (hit) t = j;
    end
    exp_auto = (t < 0);
    if (t < 0) t = PRE + AUTO_TO - 1;
    need = ((t + POST_N) << d) + 1;
    if (need + 8 > MAXN) begin
      $display("FAIL model: stream too short need=%0d limit=%0d", need, MAXN);
      $fatal(1, "stream overflow");
    end
    for (int k = 0; k < DEPTH; k++) win[k] = stream[(t - PRE + k) << d];
  endtask

  task automatic arm_capture(input int d, input int lvl, input bit slope, input bit coincident);
    bus.trig_level = DW'(lvl);
    bus.trig_slope = slope;
    bus.dec_sel    = 4'(d);
    tick();
    bus.arm = 1'b1;
    if (coincident) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = stream[0];
    end
    tick();
    bus.arm          = 1'b0;
    bus.sample_valid = 1'b0;
    check_status(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_capture(input int d, input int lvl, input bit slope, input bit coincident);
    int a;
    model(d, lvl, slope);
    arm_capture(d, lvl, slope, coincident);
    for (int i = (coincident ? 1 : 0); i < need; i++) send(stream[i]);
    idle(2);
    check_status(1'b0, 1'b1, exp_auto);
    for (int k = 0; k < 8; k++) send(stream[need + k]);
    check_read(0, win[0]);
    check_read(PRE - 1, win[PRE - 1]);
    check_read(PRE, win[PRE]);
    check_read(PRE + 1, win[PRE + 1]);
    check_read(DEPTH - 1, win[DEPTH - 1]);
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      check_read(a, win[a]);
    end
    check_status(1'b0, 1'b1, exp_auto);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.arm          = 1'b0;
    bus.trig_level   = '0;
    bus.trig_slope   = 1'b0;
    bus.dec_sel      = '0;
    bus.rd_addr      = '0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_status(1'b0, 1'b0, 1'b0);
    check_read(5, '0);
    reset_n = 1'b1;
    idle(2);
    check_status(1'b0, 1'b0, 1'b0);

    // rising ramp, 16 per sample
    for (int k = 0; k < MAXN; k++) stream[k] = DW'((16 * k) % 4096);
    run_capture(0, 2048, 1'b0, 1'b0);

    // falling square wave 4000/100
    for (int k = 0; k < MAXN; k++) stream[k] = ((k / 3) % 2 == 0) ? DW'(4000) : DW'(100);
    run_capture(0, 2000, 1'b1, 1'b0);

    // auto timeout on a flat input
    for (int k = 0; k < MAXN; k++) stream[k] = DW'(1000);
    run_capture(0, 3000, 1'b0, 1'b0);

    // decimation by 4 on a +1 ramp
    for (int k = 0; k < MAXN; k++) stream[k] = DW'(k % 4096);
    run_capture(2, 1000, 1'b0, 1'b0);

    // reset in the middle of an auto-triggered POST phase
    for (int k = 0; k < MAXN; k++) stream[k] = DW'(1000);
    arm_capture(0, 3000, 1'b0, 1'b0);
    for (int i = 0; i < PRE + AUTO_TO + 100; i++) send(stream[i]);
    check_status(1'b1, 1'b0, 1'b1);
    reset_n = 1'b0;
    check_status(1'b0, 1'b0, 1'b0);
    check_read(0, '0);
    reset_n = 1'b1;
    idle(3);
    for (int i = 0; i < 20; i++) send(DW'(3500));
    check_status(1'b0, 1'b0, 1'b0);

    // pointer wrap: write pointer restarts at 0, trigger at kept index 517 -> trig_ptr 5
    for (int k = 0; k < MAXN; k++) stream[k] = (k < 517) ? DW'(k) : DW'(3000 + (k % 1000));
    run_capture(0, 2048, 1'b0, 1'b0);

    // re-arm while ARMED; an edge inside the refilled pre-trigger window must be ignored
    for (int k = 0; k < MAXN; k++) stream[k] = DW'(10);
    arm_capture(0, 2048, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) send(DW'(10));
    check_status(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < MAXN; k++) stream[k] = (k < 300) ? DW'(10) : DW'(2500 + (k % 700));
    stream[10] = DW'(3000);
    run_capture(0, 2048, 1'b0, 1'b0);

    // randomized captures
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < MAXN; k++) stream[k] = DW'($urandom_range(0, 4095));
      run_capture($urandom_range(0, 1), $urandom_range(100, 3995), 1'($urandom_range(0, 1)), 1'(n % 2));
    end

    idle(3);
    checks++;
    if (rd_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: rd pending=%0d status pending=%0d exp=0", rd_q.size(), st_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
